// File: rtl/eth_apb_pkg.sv
// Shared types and defaults for the XCVR/PMA reconfig APB arbiter.
package eth_apb_pkg;

    localparam int TMO_CYC_DEFAULT = 4096;
    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } arb_state_e;

    // Latched request of the current winner; also drives the m_* bus directly.
    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping to 0.
module eth_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = int'(i_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!o_any && i_req[idx[IDX_W-1:0]]) begin
                o_any                   = 1'b1;
                o_grant[idx[IDX_W-1:0]] = 1'b1;
                o_idx                   = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_apb_arbiter.sv
// Round-robin sharing of one APB target between N_REQ requesters, with a pready timeout.
// ADDR_W/DATA_W may not exceed the package APB_ADDR_W/APB_DATA_W.
module eth_apb_arbiter
    import eth_apb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_psel,
    input  logic [N_REQ-1:0]          req_penable,
    input  logic [N_REQ*ADDR_W-1:0]   req_paddr,
    input  logic [N_REQ-1:0]          req_pwrite,
    input  logic [N_REQ*DATA_W-1:0]   req_pwdata,
    output logic [N_REQ-1:0]          req_pready,
    output logic [DATA_W-1:0]         req_prdata,
    output logic                      req_pserr,
    output logic                      m_psel,
    output logic                      m_penable,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic                      m_pwrite,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic                      m_pready,
    input  logic [DATA_W-1:0]         m_prdata,
    input  logic                      m_pslverr,
    output logic [$clog2(N_REQ)-1:0]  stat_grant_id,
    output logic                      stat_busy,
    output logic [15:0]               stat_tmo_count
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    arb_state_e         r_state;
    arb_state_e         w_next_state;
    apb_req_t           r_req;
    apb_req_t           w_sel;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [15:0]        r_tmo_count;
    logic               r_m_psel;
    logic               r_m_penable;
    logic               r_busy;
    logic [N_REQ-1:0]   r_req_pready;
    logic [DATA_W-1:0]  r_req_prdata;
    logic               r_req_pserr;
    logic               w_tmo_hit;
    logic               w_start;
    logic [N_REQ-1:0]   w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic               w_unused;

    assign w_unused = ^{req_penable, w_arb_grant};

    eth_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req   (req_psel),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_start = (r_state == IDLE) && w_arb_any;

    // Select the winner's request fields from the flattened buses.
    always_comb begin
        w_sel       = '0;
        w_sel.addr  = APB_ADDR_W'(req_paddr[w_arb_idx*ADDR_W +: ADDR_W]);
        w_sel.write = req_pwrite[w_arb_idx];
        w_sel.wdata = APB_DATA_W'(req_pwdata[w_arb_idx*DATA_W +: DATA_W]);
    end

    // Next-state logic; m_pready on the last allowed cycle beats the timeout.
    always_comb begin
        w_next_state = r_state;
        w_tmo_hit    = 1'b0;
        unique case (r_state)
            IDLE:    if (w_arb_any) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS: begin
                w_tmo_hit = !m_pready && (r_tmo_cnt == TMO_LAST);
                if (m_pready || w_tmo_hit) w_next_state = RESP;
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Latch the winner at grant; clearing on entry to RESP zeroes the m_* address/data bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= '0;
            r_grant_id <= '0;
        end else if (w_start) begin
            r_req      <= w_sel;
            r_grant_id <= w_arb_idx;
        end else if (w_next_state == RESP) begin
            r_req      <= '0;
        end
    end

    // ACCESS cycle counter, restarted during SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_tmo_cnt <= '0;
        else if (r_state == SETUP)  r_tmo_cnt <= '0;
        else if (r_state == ACCESS) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    // Bus control, busy flag, saturating timeout count and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_busy      <= 1'b0;
            r_tmo_count <= '0;
            r_ptr       <= '0;
        end else begin
            r_m_psel    <= (w_next_state == SETUP) || (w_next_state == ACCESS);
            r_m_penable <= (w_next_state == ACCESS);
            r_busy      <= (w_next_state != IDLE);
            if (w_tmo_hit && (r_tmo_count != 16'hFFFF)) begin
                r_tmo_count <= r_tmo_count + 16'd1;
            end
            if (r_state == RESP) begin
                r_ptr <= (r_grant_id == IDX_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    // Requester response: one-cycle pulse to the granted requester with data and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pready <= '0;
            r_req_prdata <= '0;
            r_req_pserr  <= 1'b0;
        end else if ((r_state == ACCESS) && (w_next_state == RESP)) begin
            r_req_pready <= N_REQ'(1) << r_grant_id;
            r_req_prdata <= (m_pready && !r_req.write) ? m_prdata : '0;
            r_req_pserr  <= m_pready ? m_pslverr : 1'b1;
        end else begin
            r_req_pready <= '0;
            r_req_prdata <= '0;
            r_req_pserr  <= 1'b0;
        end
    end

    assign m_psel         = r_m_psel;
    assign m_penable      = r_m_penable;
    assign m_paddr        = ADDR_W'(r_req.addr);
    assign m_pwrite       = r_req.write;
    assign m_pwdata       = DATA_W'(r_req.wdata);
    assign req_pready     = r_req_pready;
    assign req_prdata     = r_req_prdata;
    assign req_pserr      = r_req_pserr;
    assign stat_grant_id  = r_grant_id;
    assign stat_busy      = r_busy;
    assign stat_tmo_count = r_tmo_count;

endmodule
